// File: rtl/multdiv_unit_pkg.sv
// multdiv_unit_pkg
//   Shared definitions for the multiply/divide unit: FSM state encodings,
//   the most negative 32-bit value, and a helper for the last iteration
//   index of the bit-serial loop.
package multdiv_unit_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MULT = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [31:0] INT_MIN = 32'h8000_0000;

   // Counter value seen on the final iteration edge (one bit per cycle).
   function automatic int last_iter(input int width);
      return width - 1;
   endfunction

endpackage

// File: rtl/multdiv_unit_addsub33.sv
// addsub33
//   Combinational 33-bit adder/subtractor shared by the Booth multiply step
//   and the non-restoring divide step (only one operation runs at a time).
// Ports:
//   a, b  operands
//   sub   1: y = a - b, 0: y = a + b
//   y     result, wraps modulo 2^W
module addsub33 #(
   parameter int W = 33
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] y
);

   assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit
//   Sequential signed multiply/divide unit for the execute stage. Iterates
//   one bit per cycle: start edge E0 samples operands, E1..E32 iterate,
//   E33 registers result/exception and raises data_resultRDY for one cycle.
// Ports:
//   clock, reset_n   rising-edge clock, async active-low reset
//   data_operandA/B  signed operands (sampled only on a start edge)
//   ctrl_MULT/DIV    one-cycle start pulses (MULT wins if both high)
//   data_result      product[31:0] or quotient, held until next completion
//   data_exception   multiply overflow / divide-by-zero / INT_MIN/-1
//   data_resultRDY   one-cycle completion strobe
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no operation in flight, outputs hold
// MULT   | Booth radix-2 iteration, one add/sub + arithmetic shift
// DIV    | non-restoring iteration on |A|, |B|
// DONE   | register result/exception, pulse RDY, return to IDLE
module multdiv_unit
   import multdiv_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(last_iter(WIDTH));

   logic [1:0]       state;
   logic [CNT_W-1:0] counter;
   // acc is one bit wider than the operands so Booth's subtract of INT_MIN
   // and the shifted non-restoring remainder never overflow.
   logic [WIDTH:0]   acc;
   logic [WIDTH-1:0] lo;        // multiplier (mult) or quotient bits (div)
   logic [WIDTH-1:0] m_reg;     // multiplicand or |divisor|
   logic             qm1;
   logic             op_div;
   logic             neg_q;
   logic             div_zero;
   logic             div_ovf;

   logic [WIDTH:0]   add_a;
   logic [WIDTH:0]   add_b;
   logic [WIDTH:0]   add_y;
   logic             add_sub;
   logic             booth_op;
   logic [WIDTH:0]   acc_booth;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH-1:0] quot;
   logic             mult_ovf;

   addsub33 #(.W(WIDTH + 1)) u_addsub (
      .a   (add_a),
      .b   (add_b),
      .sub (add_sub),
      .y   (add_y)
   );

   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_sub = 1'b0;
      if (op_div) begin
         // Shift remainder left pulling in the next dividend bit; subtract
         // while the remainder is non-negative, add back otherwise.
         add_a   = {acc[WIDTH-1:0], lo[WIDTH-1]};
         add_b   = {1'b0, m_reg};
         add_sub = ~acc[WIDTH];
      end else begin
         // Booth pair {q0,q-1}: 10 subtracts, 01 adds.
         add_a   = acc;
         add_b   = {m_reg[WIDTH-1], m_reg};
         add_sub = lo[0];
      end
   end

   assign booth_op  = lo[0] ^ qm1;
   assign acc_booth = booth_op ? add_y : acc;
   assign abs_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
   assign abs_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
   assign quot      = neg_q ? -lo : lo;
   assign mult_ovf  = (acc[WIDTH-1:0] != {WIDTH{lo[WIDTH-1]}});

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         counter        <= '0;
         acc            <= '0;
         lo             <= '0;
         m_reg          <= '0;
         qm1            <= 1'b0;
         op_div         <= 1'b0;
         neg_q          <= 1'b0;
         div_zero       <= 1'b0;
         div_ovf        <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         if (ctrl_MULT) begin
            state    <= S_MULT;
            counter  <= '0;
            acc      <= '0;
            lo       <= data_operandB;
            m_reg    <= data_operandA;
            qm1      <= 1'b0;
            op_div   <= 1'b0;
            neg_q    <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
         end else if (ctrl_DIV) begin
            state    <= S_DIV;
            counter  <= '0;
            acc      <= '0;
            lo       <= abs_a;
            m_reg    <= abs_b;
            qm1      <= 1'b0;
            op_div   <= 1'b1;
            neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero <= (data_operandB == '0);
            div_ovf  <= (data_operandA == INT_MIN) && (data_operandB == '1);
         end else begin
            case (state)
               S_MULT: begin
                  acc     <= {acc_booth[WIDTH], acc_booth[WIDTH:1]};
                  lo      <= {acc_booth[0], lo[WIDTH-1:1]};
                  qm1     <= lo[0];
                  counter <= counter + 1'b1;
                  if (counter == LAST_ITER) state <= S_DONE;
               end
               S_DIV: begin
                  acc     <= add_y;
                  lo      <= {lo[WIDTH-2:0], ~add_y[WIDTH]};
                  counter <= counter + 1'b1;
                  if (counter == LAST_ITER) state <= S_DONE;
               end
               S_DONE: begin
                  state          <= S_IDLE;
                  data_resultRDY <= 1'b1;
                  if (!op_div) begin
                     data_result    <= lo;
                     data_exception <= mult_ovf;
                  end else if (div_zero) begin
                     data_result    <= '0;
                     data_exception <= 1'b1;
                  end else if (div_ovf) begin
                     data_result    <= INT_MIN;
                     data_exception <= 1'b1;
                  end else begin
                     data_result    <= quot;
                     data_exception <= 1'b0;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
